ram_stream_reader: RTL and testbench
====================================

// Module: ram_stream_reader
// PURPOSE
//  Burst read engine on port B of the simple dual-port block RAM (1-cycle registered read).
//  On start: reads LENGTH consecutive words from BASE_ADDR.
//  Re-times each word through a 2-entry skid FIFO.
//  Presents words on a valid/ready stream to the downstream CNN stage (conv / MAC array).
//  Under backpressure: no word lost, none duplicated.
// PARAMETERS
//  WIDTH      4  data word width, matches RAM WIDTH
//  ADDRWIDTH  8  RAM address width; address space 2**ADDRWIDTH words
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous active-low reset
//  start      in   1            1-cycle pulse: begin burst (ignored while busy=1)
//  base_addr  in   ADDRWIDTH    first read address, sampled when start accepted
//  length     in   ADDRWIDTH+1  words to read, 0..2**ADDRWIDTH, sampled with start
//  busy       out  1            high from cycle after accepted start until done
//  done       out  1            1-cycle pulse: last word accepted downstream
//  ram_enb    out  1            RAM port-B enable (read issue)
//  ram_addrb  out  ADDRWIDTH    RAM port-B address
//  ram_dob    in   WIDTH        RAM read data, valid cycle after ram_enb=1
//  m_data     out  WIDTH        stream data (FIFO head)
//  m_valid    out  1            stream valid
//  m_ready    in   1            stream ready; transfer when m_valid&m_ready
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - All outputs 0; FSM=IDLE; FIFO empty; inflight=0; counters 0.
//  FSM
//   - IDLE -> READ on start with length!=0: latch addr=base_addr, remaining=length.
//   - IDLE -> DONE on start with length==0: no RAM reads, no stream words.
//   - READ -> DRAIN when last read issued (remaining reaches 0).
//   - DRAIN -> DONE when FIFO empty and inflight==0.
//   - DONE: done=1 for exactly one cycle -> IDLE.
//   - busy=1 in READ, DRAIN, DONE.
//  Read issue
//   - In READ, ram_enb=1 iff (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
//   - On issue: ram_addrb=addr, then addr <= addr+1 (wraps mod 2**ADDRWIDTH), remaining--.
//   - ram_enb=0 in all other states.
//   - ram_addrb holds its last value when ram_enb=0.
//  Data path
//   - inflight <= ram_enb (registered).
//   - When inflight=1, ram_dob is pushed into FIFO that cycle.
//   - Push and pop may occur in the same cycle; count stays unchanged.
//   - FIFO never overflows by construction; assertion: push with count==2 is an error.
//   - m_valid = (fifo_count != 0); m_data = head entry.
//   - m_data/m_valid stable while m_valid=1 and m_ready=0.
//  Latency / throughput
//   - Accepted start at cycle T: first ram_enb at T+1, first m_valid at T+3.
//   - With m_ready held 1: one word per cycle, gap-free.
//   - done at cycle of last transfer +1.
//  Boundaries
//   - length=2**ADDRWIDTH reads every address once, wrapping from base.
//   - start while busy: ignored; latched base/length unchanged.
//   - m_ready=0 indefinitely: at most 2 words buffered; reads stall.
//   - Reset mid-burst: burst abandoned; no done pulse; outputs 0 next cycle.
// TESTING
//  1. base=0x10, len=4, m_ready=1, RAM[0x10..0x13]=1,2,3,4
//     -> ram_enb T+1..T+4; m_data 1,2,3,4 on T+3..T+6; done at T+7.
//  2. Same as 1, m_ready=0 from T+2 to T+10
//     -> ram_enb only T+1,T+2; fifo_count=2; m_data=1 held.
//     -> on release: 1,2,3,4 in order, no loss or duplicate.
//  3. base=0xFE, len=4 -> ram_addrb sequence 0xFE,0xFF,0x00,0x01.
//  4. len=0 start -> no ram_enb; m_valid stays 0; done pulse at T+1.
//  5. start again at T+2 of a len=8 burst with base=0x80 -> ignored; original 8 words only.
//  6. Random m_ready toggling (50%), len=256 -> scoreboard matches RAM contents exactly.
//     -> Also: assert rst_n=0 mid-burst -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst reader from RAM port B into a 2-entry skid FIFO feeding a valid/ready stream
module ram_stream_reader #(
  parameter int WIDTH     = 4,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] base_addr,
  input  logic [ADDRWIDTH:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_enb,
  output logic [ADDRWIDTH-1:0] ram_addrb,
  input  logic [WIDTH-1:0]     ram_dob,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]           state;
  logic [ADDRWIDTH-1:0] addr;
  logic [ADDRWIDTH-1:0] last_addr;
  logic [ADDRWIDTH:0]   remaining;
  logic                 inflight;
  logic [1:0]           count;
  logic [1:0]           cnt_nxt;
  logic [2:0]           occ;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [WIDTH-1:0]     mem [2];
  logic                 push;
  logic                 pop;
  assign push      = inflight;
  assign pop       = m_valid & m_ready;
  assign cnt_nxt   = count + {1'b0, push} - {1'b0, pop};
  assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign ram_enb   = (state == READ) && (occ < 3'd2);
  assign ram_addrb = ram_enb ? addr : last_addr;
  assign m_valid   = count != 2'd0;
  assign m_data    = mem[rd_ptr];
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  // Burst control: latch the request, issue reads, then wait for the FIFO and RAM pipe to empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      last_addr <= '0;
      remaining <= '0;
    end else begin
      if (ram_enb) last_addr <= addr;
      case (state)
        IDLE: if (start) begin
          addr      <= base_addr;
          remaining <= length;
          state     <= (length == '0) ? DONE : READ;
        end
        READ: if (ram_enb) begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == (ADDRWIDTH+1)'(1)) state <= DRAIN;
        end
        DRAIN: if (cnt_nxt == 2'd0 && !inflight) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  // Skid FIFO: capture the RAM word one cycle after issue, release on downstream handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      inflight <= ram_enb;
      count    <= cnt_nxt;
      if (push) begin
        mem[wr_ptr] <= ram_dob;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end
  // Read issue is throttled so a returning word always has a free slot
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && count == 2'd2));
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench for ram_stream_reader with a registered-read RAM model
module tb_ram_stream_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] length = '0;
  logic       m_ready = 1'b0;
  logic       busy, done, ram_enb, m_valid;
  logic [7:0] ram_addrb;
  logic [3:0] ram_dob = '0;
  logic [3:0] m_data;
  logic [3:0] ram [256];
  logic [3:0] sb [$];
  logic [7:0] aq [$];
  logic       hold = 1'b0;
  logic [3:0] held = '0;
  int         vecs = 0;
  int         errs = 0;
  int         done_cnt = 0;
  int         d0;

  ram_stream_reader #(.WIDTH(4), .ADDRWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // RAM[i] = low nibble + high nibble, so RAM[0x10..0x13] = 1,2,3,4
  initial for (int i = 0; i < 256; i++) ram[i] = 4'(i + (i >> 4));

  always @(posedge clk) if (ram_enb) ram_dob <= ram[ram_addrb];

  task automatic chk(input string n, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic miss(input string n);
    vecs++;
    errs++;
    $display("FAIL %s: DUT produced an unexpected item at %0t", n, $time);
  endtask

  // Monitor: read addresses and stream words are popped from the scoreboard queues
  always @(negedge clk) begin
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(held));
      end
      if (ram_enb) begin
        if (aq.size() == 0) miss("addr");
        else chk("addr", int'(ram_addrb), int'(aq.pop_front()));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) miss("data");
        else chk("data", int'(m_data), int'(sb.pop_front()));
      end
      if (done) done_cnt++;
      hold = m_valid && !m_ready;
      held = m_data;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] b, input int l);
    base_addr = b;
    length = 9'(l);
    start = 1'b1;
    for (int i = 0; i < l; i++) begin
      sb.push_back(ram[8'(int'(b) + i)]);
      aq.push_back(8'(int'(b) + i));
    end
    nxt();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      seen = done;
      nxt();
      if (rnd) m_ready = 1'($urandom_range(0, 1));
    end
    chk("done_seen", int'(seen), 1);
    m_ready = 1'b1;
    chk("sb_empty", sb.size(), 0);
    chk("aq_empty", aq.size(), 0);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_done"}, int'(done), 0);
    chk({n, "_enb"}, int'(ram_enb), 0);
    chk({n, "_addrb"}, int'(ram_addrb), 0);
    chk({n, "_valid"}, int'(m_valid), 0);
    chk({n, "_data"}, int'(m_data), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) nxt();
    @(negedge clk) rst_n = 1'b1;
    nxt();
    // 1: basic burst, full throughput
    m_ready = 1'b1;
    go(8'h10, 4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("t1_enb", int'(ram_enb), int'(k <= 4));
      chk("t1_valid", int'(m_valid), int'(k >= 3 && k <= 6));
      chk("t1_done", int'(done), int'(k == 7));
      chk("t1_busy", int'(busy), 1);
      nxt();
    end
    chk("t1_busy_end", int'(busy), 0);
    chk("t1_sb", sb.size(), 0);
    // 2: backpressure in cycles T+2..T+10
    go(8'h10, 4);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t2_enb", int'(ram_enb), int'(k <= 2));
      if (k >= 3) chk("t2_valid", int'(m_valid), 1);
      if (k == 10) chk("t2_head", int'(m_data), 1);
      nxt();
      m_ready = !(k + 1 >= 2 && k + 1 <= 10);
    end
    wait_done(50, 1'b0);
    // 3: address wrap
    go(8'hFE, 4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t3_addr", int'(ram_addrb), int'(8'(8'hFE + k - 1)));
      nxt();
    end
    wait_done(50, 1'b0);
    // 4: zero-length burst
    go(8'h33, 0);
    @(negedge clk);
    chk("t4_done", int'(done), 1);
    chk("t4_enb", int'(ram_enb), 0);
    chk("t4_valid", int'(m_valid), 0);
    nxt();
    @(negedge clk);
    chk("t4_done_off", int'(done), 0);
    chk("t4_busy_off", int'(busy), 0);
    nxt();
    // 5: start while busy is ignored
    d0 = done_cnt;
    go(8'h80, 8);
    base_addr = 8'h10;
    length = 9'd3;
    start = 1'b1;
    nxt();
    start = 1'b0;
    wait_done(100, 1'b0);
    nxt();
    chk("t5_done_cnt", done_cnt - d0, 1);
    // 6: full address space under random backpressure
    go(8'h37, 256);
    wait_done(3000, 1'b1);
    // reset mid-burst
    go(8'h20, 100);
    repeat (20) nxt();
    @(negedge clk) rst_n = 1'b0;
    #1 chk_zero("midrst");
    sb.delete();
    aq.delete();
    d0 = done_cnt;
    repeat (3) nxt();
    chk("midrst_no_done", done_cnt - d0, 0);
    @(negedge clk) rst_n = 1'b1;
    nxt();
    go(8'h12, 3);
    wait_done(50, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
